nexthop_route_table: RTL

NEXTHOP_ROUTE_TABLE -- requirements
Module: nexthop_route_table

---
 rtl/nexthop_route_table.sv | 128 ++++++++++++
 1 files changed

// File: rtl/nexthop_route_table.sv
// Per-VC next-hop route table. Each VC holds one route from the write that
// installs it until the packet tail drains or the input buffer empties.
module nexthop_route_table #(
  parameter int NUM_VC       = 4,
  parameter int ADDR_WIDTH   = 3,
  parameter int DRAIN_CYCLES = 1,
  localparam int VC_W  = (NUM_VC > 1) ? $clog2(NUM_VC) : 1,
  localparam int ACW   = $clog2(NUM_VC + 1),
  localparam int CNT_W = (DRAIN_CYCLES > 0) ? $clog2(DRAIN_CYCLES + 1) : 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_VC-1:0]            ib_empty_i,
  input  logic [NUM_VC-1:0]            pt_almost_done_i,
  input  logic                         nhr_write_i,
  input  logic [VC_W-1:0]              nhr_vc_i,
  input  logic [ADDR_WIDTH-1:0]        nhr_address_i,
  output logic [NUM_VC*ADDR_WIDTH-1:0] nhr_address_o,
  output logic [NUM_VC-1:0]            nhr_valid_o,
  output logic                         wr_reject_o,
  output logic [ACW-1:0]               active_cnt_o
);

  typedef enum logic [1:0] {IDLE, ROUTED, DRAIN} vc_state_e;

  vc_state_e             state_q [NUM_VC];
  vc_state_e             state_d [NUM_VC];
  logic [ADDR_WIDTH-1:0] addr_q  [NUM_VC];
  logic [ADDR_WIDTH-1:0] addr_d  [NUM_VC];
  logic [CNT_W-1:0]      cnt_q   [NUM_VC];
  logic [CNT_W-1:0]      cnt_d   [NUM_VC];
  logic [NUM_VC-1:0]     accept_vec;
  logic                  reject_d;
  logic                  reject_q;

  // NOTE: every output of a combinational block gets a default before any
  // branch; a path that leaves it unassigned would infer a latch.
  always_comb begin
    accept_vec = '0;
    for (int v = 0; v < NUM_VC; v++) begin
      state_d[v] = state_q[v];
      addr_d[v]  = addr_q[v];
      cnt_d[v]   = cnt_q[v];

      // An out-of-range VC index matches no v, so it can never be accepted.
      if (ib_empty_i[v]) begin
        state_d[v] = IDLE;
        addr_d[v]  = '0;
        cnt_d[v]   = '0;
      end else begin
        unique case (state_q[v])
          IDLE: begin
            if (nhr_write_i && nhr_vc_i == VC_W'(v) && nhr_address_i != '0) begin
              accept_vec[v] = 1'b1;
              state_d[v]    = ROUTED;
              addr_d[v]     = nhr_address_i;
            end
          end
          ROUTED: begin
            if (pt_almost_done_i[v]) begin
              if (DRAIN_CYCLES == 0) begin
                state_d[v] = IDLE;
                addr_d[v]  = '0;
                cnt_d[v]   = '0;
              end else begin
                state_d[v] = DRAIN;
                cnt_d[v]   = CNT_W'(DRAIN_CYCLES);
              end
            end
          end
          DRAIN: begin
            if (cnt_q[v] <= CNT_W'(1)) begin
              state_d[v] = IDLE;
              addr_d[v]  = '0;
              cnt_d[v]   = '0;
            end else begin
              cnt_d[v] = cnt_q[v] - CNT_W'(1);
            end
          end
          default: begin
            state_d[v] = IDLE;
            addr_d[v]  = '0;
            cnt_d[v]   = '0;
          end
        endcase
      end
    end
    reject_d = nhr_write_i && (accept_vec == '0);
  end

  // NOTE: the per-VC state/address/counter arrays are small flop arrays, not a
  // RAM, so they are reset with everything else; sequential state is updated
  // with non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int v = 0; v < NUM_VC; v++) begin
        state_q[v] <= IDLE;
        addr_q[v]  <= '0;
        cnt_q[v]   <= '0;
      end
      reject_q <= 1'b0;
    end else begin
      for (int v = 0; v < NUM_VC; v++) begin
        state_q[v] <= state_d[v];
        addr_q[v]  <= addr_d[v];
        cnt_q[v]   <= cnt_d[v];
      end
      reject_q <= reject_d;
    end
  end

  always_comb begin
    logic [ACW-1:0] pop;
    pop           = '0;
    nhr_valid_o   = '0;
    nhr_address_o = '0;
    for (int v = 0; v < NUM_VC; v++) begin
      nhr_valid_o[v] = (state_q[v] != IDLE);
      // Masking with valid keeps a non-routed VC reading zero unconditionally.
      nhr_address_o[v*ADDR_WIDTH +: ADDR_WIDTH] = nhr_valid_o[v] ? addr_q[v] : '0;
      pop = pop + ACW'(nhr_valid_o[v]);
    end
    active_cnt_o = pop;
  end

  assign wr_reject_o = reject_q;

endmodule
